// File: rtl/l2_evict_write_buffer.sv
// l2_evict_write_buffer
// Single-entry eviction write buffer sitting between the L2 controller and
// physical memory. A dirty line is absorbed into the buffer and acknowledged
// immediately so the L2 refill read can go ahead. The buffered line is written
// back to memory whenever no read is waiting. Reads that hit the buffered line
// are served from the buffer; all other reads go straight to memory.
module l2_evict_write_buffer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,

    // L2 read channel
    input  logic                  ewb_read,
    input  logic [ADDR_WIDTH-1:0] ewb_address,
    output logic [LINE_WIDTH-1:0] ewb_rdata,
    output logic                  ewb_rresp,

    // L2 eviction channel
    input  logic                  ewb_write,
    input  logic [ADDR_WIDTH-1:0] ewb_waddress,
    input  logic [LINE_WIDTH-1:0] ewb_wdata,
    output logic                  ewb_wresp,
    output logic                  ewb_ready,

    // Physical memory side
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_MEM = 2'd1,
        ST_RD_BUF = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_valid;
    logic [ADDR_WIDTH-1:0]   r_buf_addr;
    logic [LINE_WIDTH-1:0]   r_buf_data;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;

    logic                    w_hit;
    logic                    w_accept;
    logic                    w_drain_done;
    logic                    w_rd_start;
    logic [ADDR_WIDTH-1:0]   w_raddr_line;
    logic [ADDR_WIDTH-1:0]   w_waddr_line;
    logic                    w_unused_offsets;

    // Memory is line-granular: offsets are stripped before anything is stored.
    assign w_raddr_line = {ewb_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign w_waddr_line = {ewb_waddress[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // Byte offsets inside a line never influence the buffer.
    assign w_unused_offsets = ^{ewb_address[OFFSET_BITS-1:0], ewb_waddress[OFFSET_BITS-1:0]};

    // Hit only looks at the registered buffer; a line being accepted this
    // same cycle is not yet visible to the read.
    assign w_hit = r_valid &&
                   (r_buf_addr[ADDR_WIDTH-1:OFFSET_BITS] == ewb_address[ADDR_WIDTH-1:OFFSET_BITS]);

    // An eviction is taken only into an empty buffer and never while the
    // buffer is being written back; the ack is combinational.
    assign w_accept     = ewb_write && !r_valid && (r_state != ST_DRAIN);
    assign w_drain_done = (r_state == ST_DRAIN) && pmem_resp;
    assign w_rd_start   = (r_state == ST_IDLE) && ewb_read;

    assign ewb_wresp = w_accept;
    assign ewb_ready = (r_state != ST_DRAIN);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the line address of a read when it is dispatched from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_addr <= '0;
        end else if (w_rd_start) begin
            r_rd_addr <= w_raddr_line;
        end
    end

    // Buffer storage: filled on acceptance, emptied when the writeback completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_buf_addr <= w_waddr_line;
            r_buf_data <= ewb_wdata;
        end else if (w_drain_done) begin
            r_valid    <= 1'b0;
        end
    end

    // Next-state and memory/L2 handshake outputs.
    always_comb begin
        w_state_next = r_state;
        ewb_rresp    = 1'b0;
        ewb_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (r_state)
            ST_IDLE: begin
                // A waiting read always wins over starting a writeback.
                if (ewb_read) begin
                    w_state_next = w_hit ? ST_RD_BUF : ST_RD_MEM;
                end else if (r_valid) begin
                    w_state_next = ST_DRAIN;
                end
            end

            ST_RD_BUF: begin
                ewb_rresp    = 1'b1;
                ewb_rdata    = r_buf_data;
                w_state_next = ST_IDLE;
            end

            ST_RD_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = r_rd_addr;
                if (pmem_resp) begin
                    ewb_rresp    = 1'b1;
                    ewb_rdata    = pmem_rdata;
                    w_state_next = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Once started, the writeback runs to completion.
                pmem_write   = 1'b1;
                pmem_address = r_buf_addr;
                pmem_wdata   = r_buf_data;
                if (pmem_resp) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_evict_write_buffer.sv
// Testbench for l2_evict_write_buffer: directed scenarios followed by a
// randomized read/eviction mix against a line-level memory image.
module tb_l2_evict_write_buffer;

    localparam int AW = 16;
    localparam int LW = 256;
    localparam int OB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          ewb_read;
    logic [AW-1:0] ewb_address;
    logic [LW-1:0] ewb_rdata;
    logic          ewb_rresp;
    logic          ewb_write;
    logic [AW-1:0] ewb_waddress;
    logic [LW-1:0] ewb_wdata;
    logic          ewb_wresp;
    logic          ewb_ready;
    logic [AW-1:0] pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    l2_evict_write_buffer #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .OFFSET_BITS(OB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ewb_read    (ewb_read),
        .ewb_address (ewb_address),
        .ewb_rdata   (ewb_rdata),
        .ewb_rresp   (ewb_rresp),
        .ewb_write   (ewb_write),
        .ewb_waddress(ewb_waddress),
        .ewb_wdata   (ewb_wdata),
        .ewb_wresp   (ewb_wresp),
        .ewb_ready   (ewb_ready),
        .pmem_address(pmem_address),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    // ---------------- physical memory model ----------------
    logic [LW-1:0] mem    [0:2047];
    bit            mem_wr [0:2047];
    int            mem_cnt       = 0;
    int            mem_delay_cfg = 3;   // 0 selects a random 1..10 cycle delay
    bit            mem_stall     = 1'b0;
    bit            both_seen     = 1'b0;
    logic [10:0]   mem_line;

    // Untouched lines read back a pattern derived from the line number.
    function automatic logic [LW-1:0] pattern(input logic [10:0] line);
        return {8{{21'h0, line}}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (pmem_read && pmem_write) both_seen = 1'b1;
        if (reset) begin
            mem_cnt = 0;
        end else if (!mem_stall && (pmem_read || pmem_write)) begin
            if (mem_cnt == 0) begin
                mem_cnt = (mem_delay_cfg != 0) ? mem_delay_cfg : int'($urandom_range(1, 10));
            end else begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    pmem_resp = 1'b1;
                    mem_line  = pmem_address[AW-1:OB];
                    if (pmem_read) begin
                        pmem_rdata = mem_wr[mem_line] ? mem[mem_line] : pattern(mem_line);
                    end else begin
                        mem[mem_line]    = pmem_wdata;
                        mem_wr[mem_line] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 1000000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the drive point of the next cycle (2 time units after the edge).
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            if (pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            #1;
            if (ewb_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rresp(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 30; i++) begin
            if (ewb_rresp) begin
                ok = 1'b1;
                break;
            end
            cyc();
            #1;
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [LW-1:0] d1, d2, d3, d4, d5, d6;
    bit            ok, resp_seen;
    int            n;

    logic [LW-1:0] img [0:7];
    bit            rd_pend, wr_pend;
    int            rd_age, wr_age, wr_idx, idx, bad_rdata;
    logic [LW-1:0] rd_exp, wr_d;
    logic [10:0]   fl;

    initial begin
        reset        = 1'b1;
        ewb_read     = 1'b0;
        ewb_address  = '0;
        ewb_write    = 1'b0;
        ewb_waddress = '0;
        ewb_wdata    = '0;
        d1 = rand_line(); d2 = rand_line(); d3 = rand_line();
        d4 = rand_line(); d5 = rand_line(); d6 = rand_line();

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_pmem_read",  pmem_read,    0);
        check("rst_pmem_write", pmem_write,   0);
        check("rst_rresp",      ewb_rresp,    0);
        check("rst_wresp",      ewb_wresp,    0);
        check("rst_ready",      ewb_ready,    1);
        check("rst_pmem_addr",  pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata,   0);
        check("rst_rdata",      ewb_rdata,    0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Eviction into empty buffer, then writeback
        cyc();
        ewb_write = 1'b1; ewb_waddress = 16'h1240; ewb_wdata = d1;
        #1;
        check("evict_wresp_same_cycle", ewb_wresp, 1);
        cyc();
        ewb_write = 1'b0;
        wait_drain_start(ok);
        check("evict_drain_started", ok, 1);
        check("evict_drain_addr",    pmem_address, 16'h1240);
        check("evict_drain_wdata",   pmem_wdata, d1);
        check("evict_drain_ready",   ewb_ready, 0);
        check("evict_drain_no_read", pmem_read, 0);
        wait_ready(ok);
        check("evict_ready_back", ok, 1);
        check("evict_mem_written", mem[11'(16'h1240 >> OB)], d1);

        // Read hit on the buffered line (different byte offset)
        cyc();
        ewb_write = 1'b1; ewb_waddress = 16'h1240; ewb_wdata = d2;
        #1;
        check("hit_wresp", ewb_wresp, 1);
        cyc();
        ewb_write = 1'b0; ewb_read = 1'b1; ewb_address = 16'h1250;
        #1;
        check("hit_no_resp_yet", ewb_rresp, 0);
        check("hit_rdata_zero",  ewb_rdata, 0);
        cyc();
        #1;
        check("hit_rresp",        ewb_rresp, 1);
        check("hit_rdata",        ewb_rdata, d2);
        check("hit_no_pmem_read", pmem_read, 0);
        cyc();
        ewb_read = 1'b0;
        wait_drain_start(ok);
        check("hit_drain_started", ok, 1);
        check("hit_drain_wdata",   pmem_wdata, d2);
        wait_ready(ok);
        check("hit_ready_back", ok, 1);

        // Full buffer: second eviction waits for the writeback to finish
        cyc();
        ewb_write = 1'b1; ewb_waddress = 16'h5000; ewb_wdata = d3;
        #1;
        check("full_first_wresp", ewb_wresp, 1);
        cyc();
        ewb_write = 1'b0;
        wait_drain_start(ok);
        check("full_drain_started", ok, 1);
        check("full_drain_addr",    pmem_address, 16'h5000);
        ewb_write = 1'b1; ewb_waddress = 16'h3000; ewb_wdata = d4;
        resp_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("full_wresp_held_low", ewb_wresp, 0);
            if (pmem_resp) begin
                resp_seen = 1'b1;
                break;
            end
            cyc();
        end
        check("full_drain_resp_seen", resp_seen, 1);
        cyc();
        #1;
        check("full_wresp_after_drain", ewb_wresp, 1);
        cyc();
        ewb_write = 1'b0;
        wait_drain_start(ok);
        check("full_second_drain",      ok, 1);
        check("full_second_drain_addr", pmem_address, 16'h3000);
        check("full_second_drain_data", pmem_wdata, d4);
        wait_ready(ok);
        check("full_ready_back", ok, 1);

        // Simultaneous read miss and eviction into an empty buffer
        cyc();
        ewb_read = 1'b1; ewb_address = 16'h2000;
        ewb_write = 1'b1; ewb_waddress = 16'h1240; ewb_wdata = d5;
        #1;
        check("simul_wresp",        ewb_wresp, 1);
        check("simul_no_rresp",     ewb_rresp, 0);
        check("simul_no_pmem_read", pmem_read, 0);
        cyc();
        ewb_write = 1'b0;
        #1;
        check("simul_pmem_read",  pmem_read, 1);
        check("simul_pmem_addr",  pmem_address, 16'h2000);
        check("simul_no_write",   pmem_write, 0);
        wait_rresp(ok, n);
        check("simul_rresp_seen", ok, 1);
        check("simul_rd_latency", n, 3);
        check("simul_rdata",      ewb_rdata, pattern(11'(16'h2000 >> OB)));
        check("simul_no_write_during_read", pmem_write, 0);
        cyc();
        ewb_read = 1'b0;
        wait_drain_start(ok);
        check("simul_drain_after_read", ok, 1);
        check("simul_drain_addr",       pmem_address, 16'h1240);
        check("simul_drain_data",       pmem_wdata, d5);
        wait_ready(ok);
        check("simul_ready_back", ok, 1);

        // Reset in the middle of a writeback
        cyc();
        ewb_write = 1'b1; ewb_waddress = 16'h7000; ewb_wdata = d6;
        mem_stall = 1'b1;
        #1;
        check("rstmid_wresp", ewb_wresp, 1);
        cyc();
        ewb_write = 1'b0;
        wait_drain_start(ok);
        check("rstmid_drain_started", ok, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_pmem_write_async", pmem_write, 0);
        check("rstmid_ready_async",      ewb_ready, 1);
        @(posedge clk);
        #2;
        reset     = 1'b0;
        mem_stall = 1'b0;
        ewb_read  = 1'b1; ewb_address = 16'h7000;
        #1;
        check("rstmid_ready_after", ewb_ready, 1);
        check("rstmid_no_rresp",    ewb_rresp, 0);
        cyc();
        #1;
        check("rstmid_read_to_pmem", pmem_read, 1);
        check("rstmid_read_addr",    pmem_address, 16'h7000);
        wait_rresp(ok, n);
        check("rstmid_rresp_seen", ok, 1);
        check("rstmid_rdata",      ewb_rdata, pattern(11'(16'h7000 >> OB)));
        cyc();
        ewb_read = 1'b0;

        // Randomized traffic over 8 lines starting at 0x4000
        mem_delay_cfg = 0;
        for (int i = 0; i < 8; i++) img[i] = pattern(11'(11'h200 + i));
        rd_pend = 1'b0; wr_pend = 1'b0; bad_rdata = 0;
        rd_age = 0; wr_age = 0; wr_idx = 0; wr_d = '0; rd_exp = '0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!rd_pend) ewb_read = 1'b0;
            if (!wr_pend) ewb_write = 1'b0;
            if (!rd_pend && c < 2800 && $urandom_range(0, 3) == 0) begin
                idx         = int'($urandom_range(0, 7));
                ewb_address = 16'(16'h4000 + idx * 32 + int'($urandom_range(0, 31)));
                ewb_read    = 1'b1;
                rd_exp      = img[idx];      // image as seen when the read is issued
                rd_pend     = 1'b1;
                rd_age      = 0;
            end
            if (!wr_pend && c < 2800 && $urandom_range(0, 4) == 0) begin
                wr_idx       = int'($urandom_range(0, 7));
                wr_d         = rand_line();
                ewb_waddress = 16'(16'h4000 + wr_idx * 32 + int'($urandom_range(0, 31)));
                ewb_wdata    = wr_d;
                ewb_write    = 1'b1;
                wr_pend      = 1'b1;
                wr_age       = 0;
            end
            #1;
            if (!ewb_rresp && ewb_rdata !== '0) bad_rdata++;
            if (ewb_rresp && !rd_pend) bad_rdata++;
            if (wr_pend) begin
                if (ewb_wresp) begin
                    img[wr_idx] = wr_d;
                    wr_pend     = 1'b0;
                end else begin
                    wr_age++;
                    if (wr_age > 300) begin
                        check("rand_write_timeout", ewb_wresp, 1);
                        wr_pend = 1'b0;
                    end
                end
            end
            if (rd_pend) begin
                if (ewb_rresp) begin
                    check("rand_read_data", ewb_rdata, rd_exp);
                    rd_pend = 1'b0;
                end else begin
                    rd_age++;
                    if (rd_age > 60) begin
                        check("rand_read_timeout", ewb_rresp, 1);
                        rd_pend = 1'b0;
                    end
                end
            end
        end
        cyc();
        ewb_read  = 1'b0;
        ewb_write = 1'b0;
        repeat (40) cyc();
        #1;
        check("rand_final_ready", ewb_ready, 1);
        for (int i = 0; i < 8; i++) begin
            fl = 11'(11'h200 + i);
            check("rand_final_mem_line", mem_wr[fl] ? mem[fl] : pattern(fl), img[i]);
        end
        check("rand_rdata_zero_when_idle", bad_rdata, 0);
        check("never_read_and_write", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
